// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller:
// register-index width, forwarding selector codes, FSM states and watchdog default.
package hazard_ctrl_pkg;

  localparam int RFIDX_W         = 5;
  localparam int DEFAULT_TIMEOUT = 256;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source operand.
// The EX/MEM result is newer than MEM/WB, so it wins; x0 never forwards.
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [RFIDX_W-1:0] ex_rs_idx,
  input  logic [RFIDX_W-1:0] mem_rd_idx,
  input  logic               mem_reg_write,
  input  logic [RFIDX_W-1:0] wb_rd_idx,
  input  logic               wb_reg_write,
  output logic [1:0]         sel
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd_idx != '0) && (mem_rd_idx == ex_rs_idx))
      sel = FWD_EXMEM;
    else if (wb_reg_write && (wb_rd_idx != '0) && (wb_rd_idx == ex_rs_idx))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: enables/flushes, PC redirect,
// memory-wait FSM with watchdog, operand forwarding and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RFIDX_W-1:0] id_rs1_idx,
  input  logic [RFIDX_W-1:0] id_rs2_idx,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [RFIDX_W-1:0] ex_rs1_idx,
  input  logic [RFIDX_W-1:0] ex_rs2_idx,
  input  logic [RFIDX_W-1:0] ex_rd_idx,
  input  logic               ex_reg_write,
  input  logic               ex_memtoreg,
  input  logic [RFIDX_W-1:0] mem_rd_idx,
  input  logic               mem_reg_write,
  input  logic [RFIDX_W-1:0] wb_rd_idx,
  input  logic               wb_reg_write,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  input  logic               ex_branch_taken,
  input  logic               flush_all,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               exmem_en,
  output logic               memwb_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic               memwb_flush,
  output logic               pc_redirect,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel,
  output logic               dmem_timeout,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  hz_state_e       state, state_next;
  logic [WD_W-1:0] wd_cnt, wd_next;
  logic            mem_stall, wd_fire, hold, luse;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign wd_fire   = (state == HZ_MEM_WAIT) & ~dmem_ready & (wd_cnt == WD_LAST);
  // A watchdog expiry is treated as completion, so it releases the freeze.
  assign hold      = mem_stall & ~wd_fire;
  assign luse      = ex_memtoreg & ex_reg_write & (ex_rd_idx != '0) &
                     ((id_rs1_used & (id_rs1_idx == ex_rd_idx)) |
                      (id_rs2_used & (id_rs2_idx == ex_rd_idx)));

  always_comb begin
    state_next = state;
    wd_next    = wd_cnt;
    if (flush_all) begin
      state_next = HZ_RUN;
      wd_next    = '0;
    end else begin
      unique case (state)
        HZ_RUN: begin
          wd_next = '0;
          if (mem_stall) state_next = HZ_MEM_WAIT;
        end
        HZ_MEM_WAIT: begin
          if (dmem_ready || wd_fire) begin
            state_next = HZ_RUN;
            wd_next    = '0;
          end else begin
            wd_next = wd_cnt + WD_W'(1);
          end
        end
        default: begin
          state_next = HZ_RUN;
          wd_next    = '0;
        end
      endcase
    end
  end

  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en}         = '1;
    {ifid_flush, idex_flush, exmem_flush, memwb_flush}    = '0;
    pc_redirect  = 1'b0;
    dmem_timeout = wd_fire;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en}      = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
      dmem_timeout = 1'b0;
    end else if (flush_all) begin
      pc_redirect  = 1'b1;
      {ifid_flush, idex_flush, exmem_flush} = '1;
      dmem_timeout = 1'b0;
    end else if (hold) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (luse) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= HZ_RUN;
      wd_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_next;
      wd_cnt <= wd_next;
      if (!pc_en && !flush_all) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  hazard_ctrl_fwd_unit u_fwd_a (
    .ex_rs_idx     (ex_rs1_idx),
    .mem_rd_idx    (mem_rd_idx),
    .mem_reg_write (mem_reg_write),
    .wb_rd_idx     (wb_rd_idx),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_sel)
  );

  hazard_ctrl_fwd_unit u_fwd_b (
    .ex_rs_idx     (ex_rs2_idx),
    .mem_rd_idx    (mem_rd_idx),
    .mem_reg_write (mem_reg_write),
    .wb_rd_idx     (wb_rd_idx),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_sel)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int TO    = 8;
  localparam int CNT_W = 32;

  localparam logic [4:0] EN_ALL = 5'b11111, EN_RST = 5'b00000, EN_MEM = 5'b00001, EN_LU = 5'b00111;
  localparam logic [3:0] FL_NO = 4'b0000, FL_RST = 4'b1111, FL_MEM = 4'b0001, FL_LU = 4'b0100,
                         FL_BR = 4'b1100, FL_FA = 4'b1110;

  logic clk = 1'b0;
  logic rst;
  logic [RFIDX_W-1:0] id_rs1_idx, id_rs2_idx, ex_rs1_idx, ex_rs2_idx, ex_rd_idx, mem_rd_idx, wb_rd_idx;
  logic id_rs1_used, id_rs2_used, ex_reg_write, ex_memtoreg, mem_reg_write, wb_reg_write;
  logic dmem_req, dmem_ready, ex_branch_taken, flush_all;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_redirect, dmem_timeout;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    string       tag;
    logic [4:0]  en;
    logic [3:0]  fl;
    logic        redir;
    logic        tmo;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1_idx(ex_rs1_idx), .ex_rs2_idx(ex_rs2_idx), .ex_rd_idx(ex_rd_idx),
    .ex_reg_write(ex_reg_write), .ex_memtoreg(ex_memtoreg),
    .mem_rd_idx(mem_rd_idx), .mem_reg_write(mem_reg_write),
    .wb_rd_idx(wb_rd_idx), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ex_branch_taken(ex_branch_taken), .flush_all(flush_all),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .pc_redirect(pc_redirect),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Queue one cycle's expectation, then advance to just after the next clock edge.
  task automatic step(input string tag, input logic [4:0] en, input logic [3:0] fl,
                      input logic redir, input logic tmo, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.en = en; e.fl = fl; e.redir = redir; e.tmo = tmo;
    e.fa = fa; e.fb = fb; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_idx = '0; id_rs2_idx = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1_idx = '0; ex_rs2_idx = '0; ex_rd_idx = '0; ex_reg_write = 1'b0; ex_memtoreg = 1'b0;
    mem_rd_idx = '0; mem_reg_write = 1'b0; wb_rd_idx = '0; wb_reg_write = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; ex_branch_taken = 1'b0; flush_all = 1'b0;
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_ctrl"},
              64'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_redirect, dmem_timeout}),
              64'({e.en, e.fl, e.redir, e.tmo}));
        check({e.tag, "_fwd"}, 64'({fwd_a_sel, fwd_b_sel}), 64'({e.fa, e.fb}));
        check({e.tag, "_cnt"}, 64'(stall_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    step("reset", EN_RST, FL_RST, 0, 0, 2'b00, 2'b00, 0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    rst = 1'b0;
    ex_memtoreg = 1; ex_reg_write = 1; ex_rd_idx = 5;
    id_rs1_idx = 5; id_rs1_used = 1; id_rs2_idx = 1; id_rs2_used = 1;
    step("luse_rs1", EN_LU, FL_LU, 0, 0, 2'b00, 2'b00, 0);
    ex_memtoreg = 0; ex_rd_idx = 6; id_rs1_idx = 7; id_rs2_idx = 8;
    step("luse_release", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 1);
    ex_memtoreg = 1; ex_rd_idx = 0; id_rs1_idx = 0;
    step("luse_x0", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 1);
    ex_rd_idx = 7; id_rs1_idx = 2; id_rs2_idx = 7; id_rs2_used = 0;
    step("luse_rs2_unused", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 1);
    id_rs2_used = 1;
    step("luse_rs2", EN_LU, FL_LU, 0, 0, 2'b00, 2'b00, 1);
    clear_inputs();
    step("idle", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 2);

    // Forwarding selects.
    mem_rd_idx = 3; mem_reg_write = 1; wb_rd_idx = 3; wb_reg_write = 1; ex_rs1_idx = 3;
    step("fwd_exmem", EN_ALL, FL_NO, 0, 0, 2'b10, 2'b00, 2);
    mem_reg_write = 0;
    step("fwd_memwb", EN_ALL, FL_NO, 0, 0, 2'b01, 2'b00, 2);
    mem_reg_write = 1; mem_rd_idx = 4; ex_rs1_idx = 4; ex_rs2_idx = 3;
    step("fwd_split", EN_ALL, FL_NO, 0, 0, 2'b10, 2'b01, 2);
    mem_rd_idx = 0; wb_rd_idx = 0; ex_rs1_idx = 0; ex_rs2_idx = 0;
    step("fwd_x0", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 2);
    clear_inputs();

    // Four-cycle memory wait, then completion.
    dmem_req = 1;
    for (int i = 0; i < 4; i++) step("mwait", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 32'(2 + i));
    dmem_ready = 1;
    step("mwait_done", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 6);
    clear_inputs();
    step("mwait_idle", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 6);

    // Branch held during a three-cycle wait: one redirect on the ready cycle.
    dmem_req = 1; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) step("br_wait", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 32'(6 + i));
    dmem_ready = 1;
    step("br_redirect", EN_ALL, FL_BR, 1, 0, 2'b00, 2'b00, 9);
    clear_inputs();
    step("br_after", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 9);

    // Watchdog: one RUN stall cycle plus seven MEM_WAIT cycles, pulse on the 8th.
    dmem_req = 1;
    for (int i = 0; i < 8; i++) step("wd_wait", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 32'(9 + i));
    step("wd_fire", EN_ALL, FL_NO, 0, 1, 2'b00, 2'b00, 17);
    clear_inputs();
    step("wd_quiet0", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 17);
    step("wd_quiet1", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 17);

    // flush_all mid-wait returns to RUN with the watchdog cleared.
    dmem_req = 1;
    step("fa_wait0", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 17);
    step("fa_wait1", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 18);
    flush_all = 1;
    step("flush_all", EN_ALL, FL_FA, 1, 0, 2'b00, 2'b00, 19);
    flush_all = 0;
    for (int i = 0; i < 8; i++) step("fa_rewait", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 32'(19 + i));
    step("fa_wd_fire", EN_ALL, FL_NO, 0, 1, 2'b00, 2'b00, 27);

    // Reset mid-stall.
    step("rs_wait0", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 27);
    step("rs_wait1", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 28);
    rst = 1;
    step("rst_mid0", EN_RST, FL_RST, 0, 0, 2'b00, 2'b00, 29);
    step("rst_mid1", EN_RST, FL_RST, 0, 0, 2'b00, 2'b00, 0);
    rst = 0; dmem_req = 0;
    step("post_rst", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 0);
    dmem_req = 1;
    step("post_rst_wait", EN_MEM, FL_MEM, 0, 0, 2'b00, 2'b00, 0);
    dmem_req = 0;
    step("post_rst_idle", EN_ALL, FL_NO, 0, 0, 2'b00, 2'b00, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. Generates enable/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards and data-memory wait states; a small FSM handles multi-cycle memory stalls with a watchdog.
- Selects EX-stage operand forwarding.
- Keeps a stall-cycle performance count.

Parameters:
- TIMEOUT, 256, max MEM_WAIT cycles before the watchdog fires (≥2).
- CNT_W, 32, stall performance counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_rs1_idx, id_rs2_idx  in  `RFIDX_WIDTH each  ID-stage source indices
- id_rs1_used, id_rs2_used  in  1  ID instruction reads rs1/rs2
- ex_rs1_idx, ex_rs2_idx  in  `RFIDX_WIDTH  EX-stage source indices
- ex_rd_idx  in  `RFIDX_WIDTH  EX destination
- ex_reg_write, ex_memtoreg  in  1  EX writes rd / EX is a load
- mem_rd_idx  in  `RFIDX_WIDTH; mem_reg_write  in  1  MEM stage destination info
- wb_rd_idx  in  `RFIDX_WIDTH; wb_reg_write  in  1  WB stage destination info
- dmem_req  in  1  MEM stage holds a valid data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- ex_branch_taken  in  1  EX resolves a taken branch/jump
- flush_all  in  1  trap/exception flush request
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load a bubble (reg_write=0, memtoreg=0)
- pc_redirect  out  1  PC takes the branch/trap target
- fwd_a_sel, fwd_b_sel  out  2  00 = regfile, 10 = EX/MEM result, 01 = MEM/WB result
- dmem_timeout  out  1  one-cycle watchdog pulse
- stall_cnt  out  CNT_W  total stalled cycles

Behaviour:
FSM states:
- RUN → MEM_WAIT when dmem_req & !dmem_ready.
- MEM_WAIT → RUN when dmem_ready, or when the watchdog fires.
- Reset: RUN, watchdog counter 0, stall_cnt 0. During rst all enables are 0, all flushes are 1, pc_redirect=0, dmem_timeout=0.

Memory stall (combinational):
- Condition: mem_stall = dmem_req & !dmem_ready, evaluated in RUN and in MEM_WAIT.
- While mem_stall: pc/ifid/idex/exmem enables = 0; memwb_en=1 with memwb_flush=1 (bubble into WB); ex_branch_taken and the load-use check are ignored.

Load-use:
- Condition: luse = ex_memtoreg & ex_reg_write & ex_rd_idx!=0 & ((id_rs1_used & id_rs1_idx==ex_rd_idx) | (id_rs2_used & id_rs2_idx==ex_rd_idx)).
- Action when !mem_stall: pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance.

Branch:
- ex_branch_taken & !mem_stall → pc_redirect=1, ifid_flush=1, idex_flush=1. Overrides luse.
- Exactly one redirect pulse per branch, because EX advances on that cycle.

flush_all:
- Highest priority, overrides mem_stall.
- Outputs: pc_redirect=1; ifid/idex/exmem flush=1; memwb_en=1.
- FSM → RUN; watchdog counter cleared.

Priority order: rst > flush_all > mem_stall > branch > luse > normal. Normal: all enables 1, flushes 0.

Watchdog:
- The counter increments each MEM_WAIT cycle with !dmem_ready.
- When the count reaches TIMEOUT-1, dmem_timeout=1 for that cycle, the FSM returns to RUN, the pipeline advances one cycle (treated as completion), and the counter is cleared.
- The counter is also cleared on exit via dmem_ready.

Forwarding (combinational; index-0 never forwards):
- fwd_a_sel=10 if mem_reg_write & mem_rd_idx==ex_rs1_idx.
- Otherwise 01 if wb_reg_write & wb_rd_idx==ex_rs1_idx.
- Otherwise 00.
- fwd_b_sel: same rules using ex_rs2_idx.
- EX/MEM wins over MEM/WB.

stall_cnt:
- Increments (wrapping) on any cycle where pc_en=0 and rst=0.
- flush_all cycles are not counted.

Decomposition:
- Shared `defines.v` gains: FWD_RF/FWD_EXMEM/FWD_MEMWB selector constants, HZ_RUN/HZ_MEM_WAIT state encodings, and a default watchdog TIMEOUT value.
- One natural sub-module: fwd_unit (pure combinational forwarding select, instanced once per operand).

Test Plan:
1. Reset → lw x5 in EX (ex_memtoreg=1, ex_rd_idx=5), add x6,x5,x1 in ID → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1.
2. mem_rd_idx=3 & mem_reg_write, wb_rd_idx=3 & wb_reg_write, ex_rs1_idx=3, ex_rs2_idx=0 → fwd_a_sel=10, fwd_b_sel=00; drop mem_reg_write → fwd_a_sel=01.
3. dmem_req=1, dmem_ready=0 for 4 cycles, then 1 → FSM in MEM_WAIT; 4 cycles of upstream freeze with memwb_flush=1; normal enables on the ready cycle; stall_cnt=4.
4. ex_branch_taken=1 during a 3-cycle memory wait → no pc_redirect while waiting; a single pc_redirect pulse with ifid/idex flush on the ready cycle.
5. TIMEOUT=8, dmem_ready held 0 → dmem_timeout pulses on the 8th MEM_WAIT cycle, FSM returns to RUN, no further pulse.
6. flush_all asserted mid MEM_WAIT, then rst asserted mid-stall → flush outputs and RUN on the next cycle; rst forces all enables 0, stall_cnt=0, state RUN.
